mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the multicycle core, parametrised in operand width (XLEN). It takes operands from the rs1/rs2 operand registers and func3 from the instruction register on a start pulse. It then runs a radix-2 shift-add or restoring-divide sequence while the control FSM stalls on busy. The result is presented for the rd write-back mux on a one-cycle done pulse.

---
 rtl/mul_div_unit_if.sv | 23 ++
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the multicycle control path and the mul/div unit.
// Handshake: start is sampled only while busy=0; busy covers the working states; done pulses for one cycle with result valid.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, func3, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// sign fix-up at the end, one-cycle done pulse with a registered result.
module mul_div_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  mul_div_unit_if.slave     bus,
  output logic [2:0]        dbg_state
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [2:0]        op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic [XLEN-1:0]   addend;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              neg_q;
  logic              neg_r;
  logic              special;
  logic [XLEN-1:0]   special_val;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
  assign dbg_state  = state;

  // Operand decode for the LOAD state
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    is_div   = op[2];
    a_signed = is_div ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
    b_signed = is_div ? ~op[0] : (op[1:0] == 2'b01);
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    a_abs    = sa ? -a : a;
    b_abs    = sb ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    spec_val = '0;
    if (div_zero)     spec_val = op[1] ? a : '1;
    else if (div_ovf) spec_val = op[1] ? '0 : a;
  end

  // One iteration step; acc is {high, low} for multiply and {remainder, quotient} for divide
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] iter_next;

  always_comb begin
    acc_hi   = acc[2*XLEN-1:XLEN];
    acc_lo   = acc[XLEN-1:0];
    mul_sum  = {1'b0, acc_hi} + {1'b0, (acc[0] ? addend : '0)};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, addend};
    if (!is_div)
      iter_next = {mul_sum, acc_lo[XLEN-1:1]};
    else if (rem_sh >= {1'b0, addend})
      iter_next = {rem_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
    else
      iter_next = {acc[2*XLEN-2:0], 1'b0};
  end

  // Sign fix-up and output select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc_lo : acc_lo;
    rem  = neg_r ? -acc_hi : acc_hi;
    if (special)
      fix_val = special_val;
    else if (is_div)
      fix_val = op[1] ? rem : quo;
    else if (op[1:0] == 2'b00)
      fix_val = prod[XLEN-1:0];
    else
      fix_val = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state       <= IDLE;
      op          <= '0;
      a           <= '0;
      b           <= '0;
      addend      <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            op    <= bus.func3;
            a     <= bus.rs1;
            b     <= bus.rs2;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          neg_q       <= sa ^ sb;
          neg_r       <= sa;
          special     <= div_zero | div_ovf;
          special_val <= spec_val;
          addend      <= is_div ? b_abs : a_abs;
          acc         <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
          cnt         <= '0;
          if (EARLY_OUT && (div_zero || div_ovf)) begin
            result <= spec_val;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          acc <= iter_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: three builds (XLEN=32 early-out, XLEN=32 full latency, XLEN=8).
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [2:0]  st_a, st_b, st_c, state;

  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(32)) if_a ();
  mul_div_unit_if #(.XLEN(32)) if_b ();
  mul_div_unit_if #(.XLEN(8))  if_c ();

  assign if_a.start = start && (sel == 0);
  assign if_b.start = start && (sel == 1);
  assign if_c.start = start && (sel == 2);
  assign if_a.func3 = func3;
  assign if_b.func3 = func3;
  assign if_c.func3 = func3;
  assign if_a.rs1   = rs1;
  assign if_b.rs1   = rs1;
  assign if_c.rs1   = rs1[7:0];
  assign if_a.rs2   = rs2;
  assign if_b.rs2   = rs2;
  assign if_c.rs2   = rs2[7:0];

  mul_div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut_a (.clk(clk), .clr(clr), .bus(if_a), .dbg_state(st_a));
  mul_div_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut_b (.clk(clk), .clr(clr), .bus(if_b), .dbg_state(st_b));
  mul_div_unit #(.XLEN(8),  .EARLY_OUT(1'b1)) dut_c (.clk(clk), .clr(clr), .bus(if_c), .dbg_state(st_c));

  always_comb begin
    case (sel)
      0: begin busy = if_a.busy; done = if_a.done; result = if_a.result; state = st_a; end
      1: begin busy = if_b.busy; done = if_b.done; result = if_b.result; state = st_b; end
      default: begin busy = if_c.busy; done = if_c.done; result = {24'h0, if_c.result}; state = st_c; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; check latency in cycles and the result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    bit got;
    @(negedge clk);
    func3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " result"}, result, exp);
  endtask

  initial begin
    int n_done;
    int first_done;
    int second_done;
    int unstable;
    logic busy36;
    clr = 1'b0; start = 1'b0; func3 = '0; rs1 = '0; rs2 = '0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset state", {29'b0, state}, 32'd0);

    // Multiply, early-out build
    sel = 0;
    run_op("mul",     3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    run_op("mulh",    3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35);
    run_op("mulhu",   3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 35);
    run_op("mulhsu",  3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 35);
    run_op("mul nn",  3'b000, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h0000_0015, 35);
    run_op("mulh nn", 3'b001, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h0000_0000, 35);

    // Reset in the middle of a multiply
    @(negedge clk);
    func3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset done", {31'b0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    check("midreset state", {29'b0, state}, 32'd0);
    n_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midreset no done", n_done, 0);

    // Divide/remainder signs
    run_op("div",     3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35);
    run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35);
    run_op("divu",    3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 35);
    run_op("remu",    3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 35);
    run_op("div pn",  3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 35);
    run_op("rem pn",  3'b110, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 35);
    run_op("rem np",  3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 35);

    // Special cases, early-out then full latency
    for (int s = 0; s < 2; s++) begin
      int l;
      sel = s;
      l = (s == 0) ? 2 : 35;
      run_op("div0",     3'b100, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, l);
      run_op("rem0",     3'b110, 32'h0000_1234, 32'h0, 32'h0000_1234, l);
      run_op("divu0",    3'b101, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, l);
      run_op("remu0",    3'b111, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, l);
      run_op("div0 neg", 3'b100, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, l);
      run_op("rem0 neg", 3'b110, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, l);
      run_op("div ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, l);
      run_op("rem ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, l);
    end
    run_op("full divu", 3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 35);

    // start held high: accepted only from IDLE, 36 cycles apart
    sel = 0;
    @(negedge clk);
    func3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    n_done = 0; first_done = 0; second_done = 0; unstable = 0; busy36 = 1'b1;
    for (int c = 1; c <= 75 && n_done < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 36) busy36 = busy;
      if (n_done == 1 && result !== 32'hFFFF_FFEB) unstable++;
      if (done) begin
        n_done++;
        if (n_done == 1) first_done = c;
        else begin second_done = c; start = 1'b0; end
      end
    end
    start = 1'b0;
    check("held first done", first_done, 35);
    check("held second done", second_done, 71);
    check("held idle gap busy", {31'b0, busy36}, 32'd0);
    check("held result stable", unstable, 0);
    @(negedge clk);

    // Extra start pulse while busy is ignored
    @(negedge clk);
    func3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    n_done = 0; first_done = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = (c == 10);
      if (c == 10) begin func3 = 3'b100; rs1 = 32'd100; rs2 = 32'd3; end
      if (done) begin n_done++; if (first_done == 0) first_done = c; end
    end
    start = 1'b0;
    check("busy start done count", n_done, 1);
    check("busy start done cycle", first_done, 35);
    check("busy start result held", result, 32'hFFFF_FFEB);

    // Narrow build
    sel = 2;
    run_op("w8 mulhsu", 3'b010, 32'h80, 32'hFF, 32'h80, 11);
    run_op("w8 div",    3'b100, 32'hF9, 32'h02, 32'hFD, 11);
    run_op("w8 div0",   3'b100, 32'h12, 32'h00, 32'hFF, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
